// File: rtl/wave_capture_scheduler.sv
// Wave capture scheduler: ping-pong sample-buffer write sequencer with
// frame-synchronised bank swap, freeze control and windowed peak/level meter.
// Optional feature macro: WAVE_LEVEL_DECAY_EN (bar-graph level decays by one
// per window instead of following each window level directly).
module wave_capture_scheduler #(
    parameter int unsigned NSAMP = 640,
    parameter int unsigned WIN   = 40
) (
    input  logic       clk_sample,
    input  logic       reset,
    input  logic [9:0] wave_sample,
    input  logic       switch,
    input  logic       frame_sync,
    output logic       wr_en,
    output logic       wr_bank,
    output logic [9:0] wr_addr,
    output logic [9:0] wr_data,
    output logic       rd_bank,
    output logic       peak_valid,
    output logic [9:0] peak_value,
    output logic [3:0] level,
    output logic [1:0] state
);

    localparam int unsigned AW = 10;
    localparam int unsigned CW = (WIN > 1) ? $clog2(WIN) : 1;
    localparam logic [AW-1:0] LAST_ADDR = AW'(NSAMP - 1);
    localparam logic [CW-1:0] LAST_CNT  = CW'(WIN - 1);

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        FILL      = 2'd1,
        WAIT_SWAP = 2'd2,
        FROZEN    = 2'd3
    } state_t;

    state_t          st;
    logic [AW-1:0]   addr;
    logic [CW-1:0]   win_cnt;
    logic [9:0]      run_max;
    logic [9:0]      cur_max;
    logic [3:0]      win_level;

    assign state = st;

    // Running max including the current sample (so count WIN-1 sees its own sample)
    always_comb begin
        cur_max = run_max;
        if (wave_sample > run_max) begin
            cur_max = wave_sample;
        end
    end

    // Bar-graph level of the most recently closed window
    always_comb begin
        win_level = peak_value[8:5];
        if (peak_value[9]) begin
            win_level = 4'hF;
        end
    end

    // Capture FSM: write sequencing, bank swap on frame_sync, freeze handling
    always_ff @(posedge clk_sample) begin
        if (reset) begin
            st      <= IDLE;
            addr    <= '0;
            wr_en   <= 1'b0;
            wr_addr <= '0;
            wr_data <= '0;
            wr_bank <= 1'b0;
            rd_bank <= 1'b1;
        end else begin
            wr_en <= 1'b0;
            case (st)
                IDLE: begin
                    addr <= '0;
                    st   <= switch ? FROZEN : FILL;
                end
                FILL: begin
                    if (switch) begin
                        // abort: partial bank is discarded, display keeps old bank
                        addr <= '0;
                        st   <= FROZEN;
                    end else begin
                        wr_en   <= 1'b1;
                        wr_addr <= addr;
                        wr_data <= wave_sample;
                        if (addr == LAST_ADDR) begin
                            addr <= '0;
                            st   <= WAIT_SWAP;
                        end else begin
                            addr <= addr + AW'(1);
                        end
                    end
                end
                WAIT_SWAP: begin
                    // swap takes precedence over a simultaneous freeze request
                    if (frame_sync) begin
                        wr_bank <= ~wr_bank;
                        rd_bank <= ~rd_bank;
                        st      <= switch ? FROZEN : FILL;
                    end
                end
                FROZEN: begin
                    addr <= '0;
                    if (!switch) begin
                        st <= FILL;
                    end
                end
                default: begin
                    st <= IDLE;
                end
            endcase
        end
    end

    // Free-running peak window: max tracking, peak strobe and level update
    always_ff @(posedge clk_sample) begin
        if (reset) begin
            win_cnt    <= '0;
            run_max    <= '0;
            peak_valid <= 1'b0;
            peak_value <= '0;
            level      <= '0;
        end else begin
            peak_valid <= 1'b0;
            if (win_cnt == LAST_CNT) begin
                win_cnt    <= '0;
                run_max    <= '0;
                peak_value <= cur_max;
                peak_valid <= 1'b1;
            end else begin
                win_cnt <= win_cnt + CW'(1);
                run_max <= cur_max;
            end

            if (peak_valid) begin
`ifdef WAVE_LEVEL_DECAY_EN
                if (win_level >= level) begin
                    level <= win_level;
                end else begin
                    level <= level - 4'd1;
                end
`else
                level <= win_level;
`endif
            end
        end
    end

endmodule

// File: tb/tb_wave_capture_scheduler.sv
// Scoreboard bench for wave_capture_scheduler: expected writes and peaks are
// queued by the stimulus, a monitor pops and compares as the DUT presents them.
module tb_wave_capture_scheduler;

    logic       clk_sample;
    logic       reset;
    logic [9:0] wave_sample;
    logic       switch;
    logic       frame_sync;
    logic       wr_en;
    logic       wr_bank;
    logic [9:0] wr_addr;
    logic [9:0] wr_data;
    logic       rd_bank;
    logic       peak_valid;
    logic [9:0] peak_value;
    logic [3:0] level;
    logic [1:0] state;

    typedef struct packed {
        logic       bank;
        logic [9:0] addr;
        logic [9:0] data;
    } wr_exp_t;

    typedef struct packed {
        logic [9:0] pk;
        logic [3:0] lvl;
    } pk_exp_t;

    wr_exp_t wq[$];
    pk_exp_t pq[$];

    int   n_cmp;
    int   n_err;
    logic peak_chk;
    logic lvl_pend;
    logic [3:0] lvl_exp;

    wave_capture_scheduler #(.NSAMP(640), .WIN(40)) dut (
        .clk_sample (clk_sample),
        .reset      (reset),
        .wave_sample(wave_sample),
        .switch     (switch),
        .frame_sync (frame_sync),
        .wr_en      (wr_en),
        .wr_bank    (wr_bank),
        .wr_addr    (wr_addr),
        .wr_data    (wr_data),
        .rd_bank    (rd_bank),
        .peak_valid (peak_valid),
        .peak_value (peak_value),
        .level      (level),
        .state      (state)
    );

    initial clk_sample = 1'b0;
    always #5 clk_sample = ~clk_sample;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string nm, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Inputs change on the falling edge; returns at the next falling edge
    task automatic drive(input logic [9:0] s, input logic sw, input logic fs);
        wave_sample = s;
        switch      = sw;
        frame_sync  = fs;
        @(negedge clk_sample);
    endtask

    task automatic push_wr(input logic b, input int a, input logic [9:0] d);
        wr_exp_t e;
        e.bank = b;
        e.addr = 10'(a);
        e.data = d;
        wq.push_back(e);
    endtask

    task automatic push_pk(input int pk, input int lvl_def, input int lvl_dec);
        pk_exp_t e;
        e.pk = 10'(pk);
`ifdef WAVE_LEVEL_DECAY_EN
        e.lvl = 4'(lvl_dec);
`else
        e.lvl = 4'(lvl_def);
`endif
        pq.push_back(e);
    endtask

    // Monitor body, evaluated 1 time unit after every rising edge
    task automatic mon_cycle();
        wr_exp_t we;
        pk_exp_t pe;
        if (lvl_pend) begin
            chk("level_after_peak", int'(level), int'(lvl_exp));
            lvl_pend = 1'b0;
        end
        if (wr_en) begin
            if (wq.size() == 0) begin
                n_cmp++;
                n_err++;
                $display("FAIL unexpected_write: bank %0d addr %0d data %0d, none expected",
                         wr_bank, wr_addr, wr_data);
            end else begin
                we = wq.pop_front();
                n_cmp++;
                if (wr_bank != we.bank || wr_addr != we.addr || wr_data != we.data ||
                    rd_bank != ~wr_bank) begin
                    n_err++;
                    $display("FAIL write: got bank %0d/rd %0d addr %0d data %0d expected bank %0d addr %0d data %0d",
                             wr_bank, rd_bank, wr_addr, wr_data, we.bank, we.addr, we.data);
                end
            end
        end
        if (peak_valid && peak_chk) begin
            if (pq.size() == 0) begin
                n_cmp++;
                n_err++;
                $display("FAIL unexpected_peak: got peak %0d, none expected", peak_value);
            end else begin
                pe = pq.pop_front();
                chk("peak_value", int'(peak_value), int'(pe.pk));
                lvl_exp  = pe.lvl;
                lvl_pend = 1'b1;
            end
        end
    endtask

    initial begin
        n_cmp       = 0;
        n_err       = 0;
        peak_chk    = 1'b0;
        lvl_pend    = 1'b0;
        lvl_exp     = '0;
        reset       = 1'b1;
        wave_sample = '0;
        switch      = 1'b0;
        frame_sync  = 1'b0;

        fork
            forever begin
                @(posedge clk_sample);
                #1;
                mon_cycle();
            end
        join_none

        // reset state
        drive(10'd0, 1'b0, 1'b0);
        drive(10'd0, 1'b0, 1'b0);
        chk("rst_state", int'(state), 0);
        chk("rst_wr_en", int'(wr_en), 0);
        chk("rst_banks", int'({wr_bank, rd_bank}), 1);
        chk("rst_peak", int'({peak_valid, peak_value, level}), 0);

        // first fill of bank 0 with an address ramp
        reset = 1'b0;
        drive(10'd0, 1'b0, 1'b0);
        chk("idle_to_fill", int'(state), 1);
        for (int a = 0; a < 640; a++) begin
            push_wr(1'b0, a, 10'(a));
            drive(10'(a), 1'b0, 1'b0);
        end
        chk("fill_done_state", int'(state), 2);
        drive(10'd0, 1'b0, 1'b0);
        chk("wait_wr_en", int'(wr_en), 0);
        chk("fill0_all_written", wq.size(), 0);

        // hold in WAIT_SWAP, then swap on frame_sync
        for (int i = 0; i < 3; i++) drive(10'd0, 1'b0, 1'b0);
        chk("wait_hold", int'({state, wr_bank}), 4);
        drive(10'd0, 1'b0, 1'b1);
        chk("swap_banks", int'({wr_bank, rd_bank}), 2);
        chk("swap_state", int'(state), 1);

        // partial fill of bank 1, freeze at address 300
        for (int a = 0; a < 300; a++) begin
            push_wr(1'b1, a, 10'(a * 3 + 7));
            drive(10'(a * 3 + 7), 1'b0, 1'b0);
        end
        drive(10'd999, 1'b1, 1'b0);
        chk("freeze_state", int'(state), 3);
        chk("freeze_wr_en", int'(wr_en), 0);
        drive(10'd0, 1'b1, 1'b1);
        drive(10'd0, 1'b1, 1'b0);
        chk("frozen_banks", int'({wr_bank, rd_bank, state}), 11);

        // unfreeze: refill bank 1 from 0, stray frame_sync mid-fill ignored
        drive(10'd0, 1'b0, 1'b0);
        chk("unfreeze_state", int'(state), 1);
        for (int a = 0; a < 640; a++) begin
            push_wr(1'b1, a, 10'(1023 - a));
            drive(10'(1023 - a), 1'b0, (a == 100));
        end
        chk("fill1_state", int'(state), 2);
        for (int i = 0; i < 3; i++) drive(10'd0, 1'b0, 1'b0);
        chk("stray_sync_ignored", int'({state, wr_bank}), 5);

        // simultaneous switch and frame_sync: swap then freeze
        drive(10'd0, 1'b1, 1'b1);
        chk("swap_freeze_banks", int'({wr_bank, rd_bank}), 1);
        chk("swap_freeze_state", int'(state), 3);

        // fill bank 0 and reset at address 200
        drive(10'd0, 1'b0, 1'b0);
        for (int a = 0; a < 200; a++) begin
            push_wr(1'b0, a, 10'(a ^ 10'h2AA));
            drive(10'(a ^ 10'h2AA), 1'b0, 1'b0);
        end
        reset = 1'b1;
        drive(10'd5, 1'b0, 1'b0);
        chk("midfill_rst_state", int'(state), 0);
        chk("midfill_rst_wr", int'({wr_en, wr_addr, wr_data}), 0);
        chk("midfill_rst_banks", int'({wr_bank, rd_bank}), 1);
        chk("midfill_rst_peak", int'({peak_valid, peak_value, level}), 0);
        chk("all_writes_seen", wq.size(), 0);

        // peak windows, window counter aligned to reset release, FSM frozen
        reset    = 1'b0;
        peak_chk = 1'b1;
        push_pk(600, 15, 15);
        for (int i = 0; i < 40; i++) drive((i == 39) ? 10'd600 : 10'd100, 1'b1, 1'b0);
        push_pk(160, 5, 14);
        for (int i = 0; i < 40; i++) drive((i == 17) ? 10'd160 : 10'd16, 1'b1, 1'b0);
        push_pk(300, 9, 13);
        for (int i = 0; i < 40; i++) drive((i == 0) ? 10'd300 : 10'd7, 1'b1, 1'b0);
        push_pk(384, 12, 12);
        for (int i = 0; i < 40; i++) drive((i == 25) ? 10'd384 : 10'd0, 1'b1, 1'b0);
        push_pk(96, 3, 11);
        push_pk(96, 3, 10);
        push_pk(96, 3, 9);
        for (int w = 0; w < 3; w++) begin
            for (int i = 0; i < 40; i++) drive((i == 5) ? 10'd96 : 10'(i), 1'b1, 1'b0);
        end
        drive(10'd0, 1'b1, 1'b0);
        peak_chk = 1'b0;
        chk("all_peaks_seen", pq.size(), 0);
        chk("peak_phase_state", int'(state), 3);
        chk("peak_phase_no_writes", int'(wr_en), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/wave_capture_scheduler.md
WAVE_CAPTURE_SCHEDULER -- requirements
Module: wave_capture_scheduler

Interface
REQ-001 SHALL have parameter NSAMP, default 640, meaning samples per display frame buffer (bank depth).
REQ-002 SHALL have parameter WIN, default 40, meaning samples per peak-detection window.
REQ-003 SHALL have port clk_sample  input  1  sample clock; one sample per rising edge; the block's only clock.
REQ-004 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-005 SHALL have port wave_sample  input  10  unsigned audio sample, valid every clk_sample edge.
REQ-006 SHALL have port switch  input  1  freeze request; 1 = stop capture and hold the displayed bank.
REQ-007 SHALL have port frame_sync  input  1  single-cycle pulse, pre-synchronised to clk_sample, marking the display end-of-frame.
REQ-008 SHALL have port wr_en  output  1  sample-buffer write strobe.
REQ-009 SHALL have port wr_bank  output  1  bank being written.
REQ-010 SHALL have port wr_addr  output  10  write address, 0..NSAMP-1.
REQ-011 SHALL have port wr_data  output  10  sample to write.
REQ-012 SHALL have port rd_bank  output  1  bank the display reads; always the complement of wr_bank.
REQ-013 SHALL have port peak_valid  output  1  one-cycle strobe marking window close.
REQ-014 SHALL have port peak_value  output  10  maximum sample of the last closed window.
REQ-015 SHALL have port level  output  4  bar-graph level, 0..15.
REQ-016 SHALL have port state  output  2  FSM state, for debug.

Function
REQ-017 SHALL implement FSM states IDLE=0, FILL=1, WAIT_SWAP=2 and FROZEN=3.
REQ-018 In IDLE, SHALL go to FILL at the next edge if switch=0, otherwise to FROZEN.
REQ-019 In FILL, SHALL per edge register wr_en=1, wr_data=wave_sample and wr_addr=current address, then increment the address, so the write lags the input by 1 cycle.
REQ-020 In FILL, after writing address NSAMP-1, SHALL go to WAIT_SWAP with wr_en=0 and the address reset to 0.
REQ-021 In WAIT_SWAP, wr_en SHALL stay 0; on frame_sync=1, wr_bank SHALL toggle (and so rd_bank), then go to FILL, or to FROZEN if switch=1.
REQ-022 In FILL, switch=1 SHALL abort the fill: go to FROZEN, wr_en=0 from the next cycle, address reset to 0, banks not swapped (partial bank discarded).
REQ-023 In FROZEN, wr_en SHALL be 0 and the banks held; switch=0 SHALL go to FILL at address 0.
REQ-024 In WAIT_SWAP, if switch=1 and frame_sync=1 arrive in the same cycle, SHALL swap first, then go to FROZEN (the completed buffer is shown).
REQ-025 A frame_sync pulse outside WAIT_SWAP SHALL be ignored and not remembered.
REQ-026 The peak window counter SHALL run 0..WIN-1 continuously, independent of FSM state and switch.
REQ-027 The running max SHALL track the largest wave_sample in the window; at count WIN-1 it SHALL include that cycle's sample.
REQ-028 At count WIN-1, SHALL load peak_value with that max, pulse peak_valid for 1 cycle and clear the running max to 0 for the next window.
REQ-029 The window level SHALL be 15 if peak[9]=1, else peak[8:5].
REQ-030 level SHALL update only in the cycle after a peak_valid pulse.

Reset
REQ-031 reset=1 SHALL force: state=IDLE, wr_en=0, wr_addr=0, wr_data=0, wr_bank=0, rd_bank=1, peak_valid=0, peak_value=0, level=0, window counter=0, running max=0.
REQ-032 reset SHALL take priority over all other inputs, including mid-fill and mid-window; no write SHALL occur in the cycle after reset is asserted.

Configuration
REQ-033 Macro WAVE_LEVEL_DECAY_EN SHALL select the level behaviour.
REQ-034 With WAVE_LEVEL_DECAY_EN defined, each window close SHALL set level to the window level if it is >= the current level, else decrement level by 1 (never below 0).
REQ-035 Without WAVE_LEVEL_DECAY_EN, level SHALL equal the window level at every window close.

Verification
REQ-036 Reset release, switch=0, wave_sample=addr-ramp: wr_en high for exactly 640 cycles; wr_addr 0..639; wr_bank=0; then state=2.
REQ-037 In WAIT_SWAP with frame_sync pulsed once: wr_bank=1, rd_bank=0 next cycle; refill begins at address 0.
REQ-038 switch=1 at wr_addr=300: wr_en=0 next cycle, state=3, banks unchanged; switch=0 restarts fill at address 0.
REQ-039 One window of 39 samples of 100 plus one sample of 600: peak_valid pulse, peak_value=600, level=15; a window of max 0x0A0 gives level=5.
REQ-040 WAVE_LEVEL_DECAY_EN defined, window levels 12 then 3,3,3: level goes 12,11,10,9; undefined: 12,3,3,3.
REQ-041 switch=1 and frame_sync in the same WAIT_SWAP cycle: banks swap, state=3; reset asserted at wr_addr=200: all REQ-031 values next cycle.
